cpu_rf_wb: RTL and testbench

//  Writeback unit driving the CPU register file's single write port (wrt_en/wrt_sel/wrt_data).

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/cpu_wb_fifo.sv | 48 ++++
 rtl/cpu_rf_wb.sv | 135 +++++++++++++
 tb/tb_cpu_rf_wb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and writeback request types for the register-file writeback path.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_SEL_W = 4;
  localparam int NUM_REGS  = 2 ** REG_SEL_W;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LQ   = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_SEL_W-1:0] sel);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/cpu_wb_fifo.sv
// Load queue: synchronous FIFO of writeback requests with full/empty flags.
// Head is read combinationally, so an entry pushed at edge N is visible in cycle N+1.
module cpu_wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  wb_req_t i_wdata,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           w_push;
  logic           w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/cpu_rf_wb.sv
// Register-file writeback: ALU-priority arbiter with LQ anti-starvation, registered write port, load scoreboard.
// Optional CPU_WB_BYPASS_EN: a load response arriving while idle is written directly, skipping the LQ.
module cpu_rf_wb
  import cpu_pkg::*;
#(
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_alu_vld,
  output logic                 o_alu_rdy,
  input  logic [REG_SEL_W-1:0] i_alu_sel,
  input  logic [DATA_W-1:0]    i_alu_data,
  input  logic                 i_mem_vld,
  output logic                 o_mem_rdy,
  input  logic [REG_SEL_W-1:0] i_mem_sel,
  input  logic [DATA_W-1:0]    i_mem_data,
  input  logic                 i_iss_ld_vld,
  input  logic [REG_SEL_W-1:0] i_iss_ld_sel,
  output logic [NUM_REGS-1:0]  o_busy,
  output logic                 o_wrt_en,
  output logic [REG_SEL_W-1:0] o_wrt_sel,
  output logic [DATA_W-1:0]    o_wrt_data,
  output logic                 o_err
);

  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  wb_req_t             w_alu_req;
  wb_req_t             w_mem_req;
  wb_req_t             w_lq_head;
  wb_req_t             w_win_req;
  wb_src_e             w_src;
  logic                w_lq_full;
  logic                w_lq_empty;
  logic                w_lq_push;
  logic                w_lq_pop;
  logic                w_force_lq;
  logic                w_bypass;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [NUM_REGS-1:0] r_busy;

  assign w_alu_req  = '{sel: i_alu_sel, data: i_alu_data};
  assign w_mem_req  = '{sel: i_mem_sel, data: i_mem_data};

`ifdef CPU_WB_BYPASS_EN
  assign w_bypass = w_lq_empty && !i_alu_vld && i_mem_vld;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_force_lq = (r_starve_cnt == STARVE_W'(STARVE_MAX)) && !w_lq_empty;
  assign o_alu_rdy  = !w_force_lq;
  assign o_mem_rdy  = !w_lq_full;
  assign w_lq_push  = i_mem_vld && o_mem_rdy && !w_bypass;
  assign o_busy     = r_busy;

  cpu_wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_lq_push),
    .i_wdata (w_mem_req),
    .i_pop   (w_lq_pop),
    .o_head  (w_lq_head),
    .o_full  (w_lq_full),
    .o_empty (w_lq_empty)
  );

  // A bypassed response counts as a load win so the scoreboard clears the same way.
  always_comb begin
    w_src     = WB_NONE;
    w_win_req = w_alu_req;
    w_lq_pop  = 1'b0;
    if (i_alu_vld && !w_force_lq) begin
      w_src = WB_ALU;
    end else if (!w_lq_empty) begin
      w_src     = WB_LQ;
      w_win_req = w_lq_head;
      w_lq_pop  = 1'b1;
    end else if (w_bypass) begin
      w_src     = WB_LQ;
      w_win_req = w_mem_req;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
    end else if (w_lq_empty || w_lq_pop) begin
      r_starve_cnt <= '0;
    end else if (w_src == WB_ALU && r_starve_cnt != STARVE_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // R0 winners are consumed but never written; sel/data hold on idle or dropped cycles.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wrt_en   <= 1'b0;
      o_wrt_sel  <= '0;
      o_wrt_data <= '0;
      o_err      <= 1'b0;
    end else if (w_src != WB_NONE) begin
      if (w_win_req.sel != '0) begin
        o_wrt_en   <= 1'b1;
        o_wrt_sel  <= w_win_req.sel;
        o_wrt_data <= w_win_req.data;
        o_err      <= 1'b0;
      end else begin
        o_wrt_en   <= 1'b0;
        o_err      <= (w_win_req.data != '0);
      end
    end else begin
      o_wrt_en <= 1'b0;
      o_err    <= 1'b0;
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_iss_ld_vld && i_iss_ld_sel != '0) w_set_mask = reg_onehot(i_iss_ld_sel);
    if (w_src == WB_LQ) w_clr_mask = reg_onehot(w_win_req.sel);
  end

  // Set after clear so a reissue in the retiring cycle keeps the register busy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

endmodule

// File: tb/tb_cpu_rf_wb.sv
// Directed bench for cpu_rf_wb; load-latency expectations follow CPU_WB_BYPASS_EN.
module tb_cpu_rf_wb;

`ifdef CPU_WB_BYPASS_EN
  localparam int LD_LAT = 1;
`else
  localparam int LD_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_vld = 1'b0;
  logic        alu_rdy;
  logic [3:0]  alu_sel = '0;
  logic [31:0] alu_data = '0;
  logic        mem_vld = 1'b0;
  logic        mem_rdy;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_data = '0;
  logic        iss_ld_vld = 1'b0;
  logic [3:0]  iss_ld_sel = '0;
  logic [15:0] busy;
  logic        wrt_en;
  logic [3:0]  wrt_sel;
  logic [31:0] wrt_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_rf_wb dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_vld    (alu_vld),
    .o_alu_rdy    (alu_rdy),
    .i_alu_sel    (alu_sel),
    .i_alu_data   (alu_data),
    .i_mem_vld    (mem_vld),
    .o_mem_rdy    (mem_rdy),
    .i_mem_sel    (mem_sel),
    .i_mem_data   (mem_data),
    .i_iss_ld_vld (iss_ld_vld),
    .i_iss_ld_sel (iss_ld_sel),
    .o_busy       (busy),
    .o_wrt_en     (wrt_en),
    .o_wrt_sel    (wrt_sel),
    .o_wrt_data   (wrt_data),
    .o_err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_vld = 1'b0; mem_vld = 1'b0; iss_ld_vld = 1'b0;
  endtask

  task automatic test_reset();
    alu_vld = 1'b1; alu_sel = 4'd9; alu_data = 32'h9;
    iss_ld_vld = 1'b1; iss_ld_sel = 4'd1; mem_vld = 1'b1; mem_sel = 4'd1; mem_data = 32'h11;
    tick();
    iss_ld_sel = 4'd2; mem_sel = 4'd2; mem_data = 32'h22;
    tick();
    idle_inputs();
    #1;
    n_cmp++; if (busy !== 16'h0006) begin n_bad++; $display("FAIL pre_reset_busy: got %h want %h", busy, 16'h0006); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (wrt_en !== 1'b0) begin n_bad++; $display("FAIL reset_wrt_en: got %b want 0", wrt_en); end
    n_cmp++; if (wrt_sel !== 4'd0) begin n_bad++; $display("FAIL reset_wrt_sel: got %h want 0", wrt_sel); end
    n_cmp++; if (wrt_data !== 32'd0) begin n_bad++; $display("FAIL reset_wrt_data: got %h want 0", wrt_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    n_cmp++; if (mem_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_mem_rdy: got %b want 1", mem_rdy); end
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (wrt_en !== 1'b0) begin n_bad++; $display("FAIL reset_lq_discard: cycle %0d got wrt_en %b want 0", k, wrt_en); end
    end
  endtask

  task automatic test_alu_single();
    alu_vld = 1'b1; alu_sel = 4'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (alu_rdy !== 1'b1) begin n_bad++; $display("FAIL alu_rdy_idle: got %b want 1", alu_rdy); end
    tick();
    alu_vld = 1'b0;
    n_cmp++; if ({wrt_en, wrt_sel, wrt_data} !== {1'b1, 4'd5, 32'hDEADBEEF})
      begin n_bad++; $display("FAIL alu_write: got en=%b sel=%h data=%h want en=1 sel=5 data=deadbeef", wrt_en, wrt_sel, wrt_data); end
    tick();
    n_cmp++; if ({wrt_en, wrt_sel, wrt_data} !== {1'b0, 4'd5, 32'hDEADBEEF})
      begin n_bad++; $display("FAIL alu_one_cycle: got en=%b sel=%h data=%h want en=0 sel=5 data=deadbeef", wrt_en, wrt_sel, wrt_data); end
  endtask

  task automatic test_starve();
    logic [31:0] adata;
    logic [3:0]  esel;
    logic [31:0] edata;
    adata = 32'h100;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) begin
        tick();
        esel  = (k == 5) ? 4'd3 : 4'd4;
        edata = (k == 5) ? 32'h333 : (k == 6) ? 32'h104 : 32'h100 + 32'(k - 1);
        n_cmp++; if ({wrt_en, wrt_sel, wrt_data} !== {1'b1, esel, edata})
          begin n_bad++; $display("FAIL starve_write: cycle %0d got en=%b sel=%h data=%h want en=1 sel=%h data=%h", k, wrt_en, wrt_sel, wrt_data, esel, edata); end
      end
      alu_vld = (k <= 5); alu_sel = 4'd4; alu_data = adata;
      mem_vld = (k == 0); mem_sel = 4'd3; mem_data = 32'h333;
      #1;
      if (k <= 5) begin
        n_cmp++; if (alu_rdy !== (k != 4)) begin n_bad++; $display("FAIL starve_alu_rdy: cycle %0d got %b want %b", k, alu_rdy, (k != 4)); end
      end
      if (k != 4) adata = adata + 1;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_lq_full();
    int idx;
    int nrx;
    idx = 0; nrx = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin
        tick();
        if (wrt_en && wrt_sel >= 4'd8) begin
          n_cmp++; if (wrt_sel !== 4'(8 + nrx) || wrt_data !== 32'hA0 + 32'(nrx))
            begin n_bad++; $display("FAIL lq_order: entry %0d got sel=%h data=%h want sel=%h data=%h", nrx, wrt_sel, wrt_data, 4'(8 + nrx), 32'hA0 + 32'(nrx)); end
          nrx++;
        end
      end
      alu_vld = (k <= 5); alu_sel = 4'd6; alu_data = 32'(k);
      mem_vld = (idx < 5); mem_sel = 4'(8 + idx); mem_data = 32'hA0 + 32'(idx);
      #1;
      if (k <= 5) begin
        n_cmp++; if (mem_rdy !== (k != 4)) begin n_bad++; $display("FAIL lq_mem_rdy: cycle %0d got %b want %b", k, mem_rdy, (k != 4)); end
      end
      if (mem_vld && mem_rdy) idx++;
    end
    idle_inputs();
    n_cmp++; if (nrx !== 5) begin n_bad++; $display("FAIL lq_count: got %0d writes want 5", nrx); end
  endtask

  task automatic load_seq(input logic [31:0] d, input logic reissue);
    for (int k = 0; k < LD_LAT; k++) begin
      mem_vld = (k == 0); mem_sel = 4'd7; mem_data = d;
      iss_ld_vld = reissue && (k == LD_LAT - 1); iss_ld_sel = 4'd7;
      tick();
      idle_inputs();
      if (k < LD_LAT - 1) begin
        n_cmp++; if (busy[7] !== 1'b1 || wrt_en !== 1'b0)
          begin n_bad++; $display("FAIL sb_pending: got busy7=%b en=%b want busy7=1 en=0", busy[7], wrt_en); end
      end
    end
  endtask

  task automatic test_scoreboard();
    iss_ld_vld = 1'b1; iss_ld_sel = 4'd7;
    tick();
    idle_inputs();
    n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_set: got %h want 0080", busy); end
    load_seq(32'h77, 1'b0);
    n_cmp++; if ({wrt_en, wrt_sel, wrt_data, busy} !== {1'b1, 4'd7, 32'h77, 16'h0000})
      begin n_bad++; $display("FAIL sb_clear: got en=%b sel=%h data=%h busy=%h want en=1 sel=7 data=77 busy=0000", wrt_en, wrt_sel, wrt_data, busy); end
    iss_ld_vld = 1'b1; iss_ld_sel = 4'd7;
    tick();
    idle_inputs();
    load_seq(32'h78, 1'b1);
    n_cmp++; if ({wrt_en, wrt_sel, wrt_data, busy} !== {1'b1, 4'd7, 32'h78, 16'h0080})
      begin n_bad++; $display("FAIL sb_reissue: got en=%b sel=%h data=%h busy=%h want en=1 sel=7 data=78 busy=0080", wrt_en, wrt_sel, wrt_data, busy); end
    alu_vld = 1'b1; alu_sel = 4'd7; alu_data = 32'hAB;
    tick();
    idle_inputs();
    n_cmp++; if ({wrt_en, wrt_sel, wrt_data, busy} !== {1'b1, 4'd7, 32'hAB, 16'h0080})
      begin n_bad++; $display("FAIL sb_alu_busy: got en=%b sel=%h data=%h busy=%h want en=1 sel=7 data=ab busy=0080", wrt_en, wrt_sel, wrt_data, busy); end
    iss_ld_vld = 1'b1; iss_ld_sel = 4'd0;
    tick();
    idle_inputs();
    n_cmp++; if (busy !== 16'h0080) begin n_bad++; $display("FAIL sb_r0_ignored: got %h want 0080", busy); end
    load_seq(32'h79, 1'b0);
    n_cmp++; if (busy !== 16'h0000) begin n_bad++; $display("FAIL sb_final_clear: got %h want 0000", busy); end
    tick();
  endtask

  task automatic test_r0();
    alu_vld = 1'b1; alu_sel = 4'd0; alu_data = 32'h1;
    #1;
    n_cmp++; if (alu_rdy !== 1'b1) begin n_bad++; $display("FAIL r0_alu_rdy: got %b want 1", alu_rdy); end
    tick();
    idle_inputs();
    n_cmp++; if ({wrt_en, err} !== 2'b01) begin n_bad++; $display("FAIL r0_err_pulse: got en=%b err=%b want en=0 err=1", wrt_en, err); end
    tick();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL r0_err_one_cycle: got %b want 0", err); end
    alu_vld = 1'b1; alu_sel = 4'd0; alu_data = 32'h0;
    tick();
    idle_inputs();
    n_cmp++; if ({wrt_en, err} !== 2'b00) begin n_bad++; $display("FAIL r0_zero_no_err: got en=%b err=%b want en=0 err=0", wrt_en, err); end
    for (int k = 0; k < LD_LAT; k++) begin
      mem_vld = (k == 0); mem_sel = 4'd0; mem_data = 32'h5;
      tick();
      idle_inputs();
    end
    n_cmp++; if ({wrt_en, err} !== 2'b01) begin n_bad++; $display("FAIL r0_load_err: got en=%b err=%b want en=0 err=1", wrt_en, err); end
    tick();
    n_cmp++; if ({wrt_en, err} !== 2'b00) begin n_bad++; $display("FAIL r0_load_popped: got en=%b err=%b want en=0 err=0", wrt_en, err); end
  endtask

  task automatic test_latency();
    mem_vld = 1'b1; mem_sel = 4'd2; mem_data = 32'h1234;
    tick();
    idle_inputs();
    n_cmp++; if (wrt_en !== (LD_LAT == 1)) begin n_bad++; $display("FAIL lat_n1: got %b want %b", wrt_en, (LD_LAT == 1)); end
    tick();
    n_cmp++; if (wrt_en !== (LD_LAT == 2)) begin n_bad++; $display("FAIL lat_n2: got %b want %b", wrt_en, (LD_LAT == 2)); end
    n_cmp++; if ({wrt_sel, wrt_data} !== {4'd2, 32'h1234})
      begin n_bad++; $display("FAIL lat_data: got sel=%h data=%h want sel=2 data=1234", wrt_sel, wrt_data); end
    tick();
    n_cmp++; if (wrt_en !== 1'b0) begin n_bad++; $display("FAIL lat_single: got %b want 0", wrt_en); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    test_reset();
    test_alu_single();
    test_starve();
    test_lq_full();
    test_scoreboard();
    test_r0();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
